pcm_packetizer: RTL

Parametrised successor to the PCM-to-UDP framer. It buffers a muxed PCM sample stream of configurable sample width in an internal FIFO and emits UDP header and payload handshakes. Each packet carries a sequence number and an explicit sample count. Partial packets are flushed on a programmable timeout, and input samples lost to FIFO overflow are counted. It sits between the channel mux and the UDP TX stack, in a single clock domain (clk).

---
 rtl/pcm_packetizer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pcm_packetizer.sv
// rtl/pcm_packetizer.sv - PCM sample FIFO feeding a UDP header/payload framer
module pcm_packetizer #(
  parameter int         SAMPLE_BYTES = 2,
  parameter int         FIFO_AW      = 10,
  parameter int         MAX_SAMPLES  = 660,
  parameter logic [7:0] PACKET_TYPE  = 8'he1,
  parameter int         TIMEOUT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pcm_valid,
  input  logic [8*SAMPLE_BYTES-1:0] pcm_data,
  output logic                      hdr_valid,
  input  logic                      hdr_ready,
  output logic [15:0]               udp_length,
  output logic [7:0]                tdata,
  output logic                      tvalid,
  input  logic                      tready,
  output logic                      tlast,
  input  logic                      tx_start,
  input  logic [23:0]               tx_total,
  output logic [23:0]               tx_left,
  input  logic [FIFO_AW:0]          tx_th,
  input  logic [TIMEOUT_W-1:0]      timeout,
  input  logic [7:0]                channel_choose,
  input  logic                      seq_clear,
  output logic [15:0]               overflow_cnt
);
  localparam int          SW      = 8 * SAMPLE_BYTES;
  localparam int          DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_V = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [1:0]  SB_LAST = 2'(SAMPLE_BYTES - 1);
  localparam logic [23:0] ENDLESS = 24'hffffff;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HDR, S_PAYLOAD} state_t;
  state_t state, state_nxt;

  logic [2:0]           start_sync;
  logic                 load;
  logic [SW-1:0]        mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     avail;
  logic                 full, armed, wr_en, pop, flush;
  logic [TIMEOUT_W-1:0] tcnt;
  logic                 launch;
  logic [23:0]          n_calc;
  logic [15:0]          n_lat, seq, seq_hdr, byte_idx;
  logic [1:0]           sub_idx;
  logic                 beat, last_beat;
  logic [SW-1:0]        head, head_shift;
  logic [4:0]           shamt;

  // two synchronising flops, third flop only for edge detection
  always_ff @(posedge clk) begin
    if (rst) start_sync <= 3'b000;
    else     start_sync <= {start_sync[1:0], tx_start};
  end
  assign load = start_sync[1] & ~start_sync[2];

  assign armed  = (tx_left != 24'd0);
  assign full   = (avail == DEPTH_V);
  assign wr_en  = pcm_valid && !full && armed;
  assign beat   = tvalid && tready;
  assign last_beat = beat && tlast;
  assign pop    = beat && (byte_idx >= 16'd6) && (sub_idx == SB_LAST);
  assign flush  = !armed && (state == S_IDLE || state == S_WAIT);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= pcm_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      avail  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      avail <= avail + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      overflow_cnt <= 16'd0;
    else if (pcm_valid && full && armed && overflow_cnt != 16'hffff)
      overflow_cnt <= overflow_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      tx_left <= 24'd0;
    else if (load)
      tx_left <= tx_total;
    else if (pop && armed && tx_left != ENDLESS)
      tx_left <= tx_left - 1'b1;
  end

  assign launch = (avail != '0) &&
                  ((avail >= tx_th) || (timeout != '0 && tcnt >= timeout));

  always_comb begin
    n_calc = 24'(avail);
    if (n_calc > 24'(MAX_SAMPLES)) n_calc = 24'(MAX_SAMPLES);
    if (n_calc > tx_left)          n_calc = tx_left;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (armed) state_nxt = S_WAIT;
      S_WAIT:    if (!armed) state_nxt = S_IDLE;
                 else if (launch) state_nxt = S_HDR;
      S_HDR:     if (hdr_ready) state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (last_beat) state_nxt = S_WAIT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hdr_valid = (state == S_HDR);
    tvalid    = (state == S_PAYLOAD);
    tlast     = (state == S_PAYLOAD) && (byte_idx == udp_length - 16'd1);
  end

  // header fields are frozen at launch so seq_clear cannot alter a packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat      <= 16'd0;
      udp_length <= 16'd0;
      seq_hdr    <= 16'd0;
    end else if (state == S_WAIT && state_nxt == S_HDR) begin
      n_lat      <= 16'(n_calc);
      udp_length <= 16'(n_calc) * 16'(SAMPLE_BYTES) + 16'd6;
      seq_hdr    <= seq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || seq_clear) seq <= 16'd0;
    else if (last_beat)   seq <= seq + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || state != S_PAYLOAD) begin
      byte_idx <= 16'd0;
      sub_idx  <= 2'd0;
    end else if (beat) begin
      byte_idx <= byte_idx + 1'b1;
      if (byte_idx >= 16'd6)
        sub_idx <= (sub_idx == SB_LAST) ? 2'd0 : sub_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT || state_nxt != S_WAIT || avail == '0)
      tcnt <= '0;
    else if (avail < tx_th && tcnt != '1)
      tcnt <= tcnt + 1'b1;
  end

  // samples go out MSB first: shift the FIFO head down by the remaining byte count
  assign head       = mem[rd_ptr];
  assign shamt      = {SB_LAST - sub_idx, 3'b000};
  assign head_shift = head >> shamt;

  always_comb begin
    case (byte_idx)
      16'd0:   tdata = channel_choose;
      16'd1:   tdata = PACKET_TYPE;
      16'd2:   tdata = seq_hdr[15:8];
      16'd3:   tdata = seq_hdr[7:0];
      16'd4:   tdata = n_lat[15:8];
      16'd5:   tdata = n_lat[7:0];
      default: tdata = head_shift[7:0];
    endcase
  end

endmodule
